// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// write-back steps and drives the datapath enables, mux selects and ALU code.
module multicycle_controller #(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pcen,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic [1:0]      pcsrc,
  output logic [2:0]      aluctrl,
  output logic            instr_done,
  output logic            illegal
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
  localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
  localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
  localparam logic [FN_W-1:0] FN_OR  = FN_W'(6'b100101);
  localparam logic [FN_W-1:0] FN_SLT = FN_W'(6'b101010);

  logic [3:0] state, next;
  logic       pcwrite, branch;
  logic       memread_s, memwrite_s, irwrite_s, regwrite_s, done_s, illegal_s;
  logic [2:0] funct_alu;
  logic       funct_ok;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (funct)
      FN_ADD:  funct_alu = 3'b010;
      FN_SUB:  funct_alu = 3'b110;
      FN_AND:  funct_alu = 3'b000;
      FN_OR:   funct_alu = 3'b001;
      FN_SLT:  funct_alu = 3'b111;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    next       = state;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_s = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluctrl    = 3'b010;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    case (state)
      FETCH: begin
        memread_s = 1'b1;
        alusrcb   = 2'b01;
        irwrite_s = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) next = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = RTYPEEX;
          OP_BEQ:       next = BEQEX;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JEX;
          default: begin
            illegal_s = 1'b1;
            done_s    = 1'b1;
            next      = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread_s = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next = MEMWB;
      end
      MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
        done_s     = 1'b1;
        next       = FETCH;
      end
      MEMWR: begin
        memwrite_s = 1'b1;
        iord       = 1'b1;
        done_s     = mem_ready;
        if (mem_ready) next = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluctrl = funct_alu;
        if (funct_ok) begin
          next = RTYPEWB;
        end else begin
          illegal_s = 1'b1;
          done_s    = 1'b1;
          next      = FETCH;
        end
      end
      RTYPEWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
        aluctrl    = funct_alu;
        done_s     = 1'b1;
        next       = FETCH;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluctrl = 3'b110;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        done_s  = 1'b1;
        next    = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next    = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
        next       = FETCH;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = 2'b10;
        done_s  = 1'b1;
        next    = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next;
  end

  // Side-effecting strobes are suppressed while reset is held so an aborted
  // instruction cannot write the register file or memory.
  assign pcen       = ~rst & (pcwrite | (branch & zero));
  assign memread    = ~rst & memread_s;
  assign memwrite   = ~rst & memwrite_s;
  assign irwrite    = ~rst & irwrite_s;
  assign regwrite   = ~rst & regwrite_s;
  assign instr_done = ~rst & done_s;
  assign illegal    = ~rst & illegal_s;

endmodule
